// File: rtl/dcache_line_mover_pkg.sv
// Shared definitions for the cache line movers: FSM state encoding and RAM direction constants.
package dcache_line_mover_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        COOL  = 3'd4
    } state_t;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

endpackage

// File: rtl/dcache_line_mover_line_shift_buf.sv
// One cache line of byte storage: parallel load, byte-indexed write, byte-indexed read.
module line_shift_buf #(
    parameter  int unsigned BLOCK_WIDTH = 4,
    localparam int unsigned BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
    input  logic                     clkIn,
    input  logic                     resetIn,
    input  logic                     loadIn,
    input  logic [BLOCK_SIZE*8-1:0]  loadData,
    input  logic                     writeIn,
    input  logic [BLOCK_WIDTH-1:0]   writeIdx,
    input  logic [7:0]               writeByte,
    input  logic [BLOCK_WIDTH-1:0]   readIdx,
    output logic [7:0]               readByte,
    output logic [BLOCK_SIZE*8-1:0]  lineOut
);

    logic [BLOCK_SIZE-1:0][7:0] lineReg;

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            lineReg <= '0;
        end else if (loadIn) begin
            lineReg <= loadData;
        end else if (writeIn) begin
            lineReg[writeIdx] <= writeByte;
        end
    end

    assign readByte = lineReg[readIdx];
    assign lineOut  = lineReg;

endmodule

// File: rtl/dcache_line_mover.sv
// Data-cache miss engine: byte-serial line writebacks to RAM and line fills from RAM.
module dcache_line_mover
    import dcache_line_mover_pkg::*;
#(
    parameter  int unsigned BLOCK_WIDTH = 4,
    localparam int unsigned BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      clearIn,
    input  logic                      missIn,
    input  logic [31-BLOCK_WIDTH:0]   missAddrIn,
    input  logic                      readWriteIn,
    input  logic [BLOCK_SIZE*8-1:0]   writeBackIn,
    output logic                      memDataValid,
    output logic [31-BLOCK_WIDTH:0]   memAddr,
    output logic [BLOCK_SIZE*8-1:0]   memDataOut,
    output logic                      acceptWrite,
    output logic                      busy,
    output logic [31:0]               ramAddrOut,
    output logic [7:0]                ramDataOut,
    output logic                      ramWriteOut,
    input  logic [7:0]                ramDataIn
);

    localparam logic [BLOCK_WIDTH:0] CNT_FULL = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
    localparam logic [BLOCK_WIDTH:0] CNT_LAST = (BLOCK_WIDTH+1)'(BLOCK_SIZE - 1);

    state_t                    state, stateNext;
    logic [BLOCK_WIDTH:0]      cnt, cntNext;
    logic [31-BLOCK_WIDTH:0]   lineAddr;
    logic                      isFill;
    logic                      startReq;
    logic                      bufLoad, bufWrite;
    logic [BLOCK_WIDTH-1:0]    capIdx;
    logic [7:0]                bufByte;
    logic [BLOCK_SIZE*8-1:0]   bufLine;

    // A flush cancels a pending fill request, but a writeback still has to go out.
    assign startReq = missIn && !(readWriteIn && clearIn);
    assign capIdx   = cnt[BLOCK_WIDTH-1:0] - 1'b1;

    line_shift_buf #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_lineBuf (
        .clkIn     (clkIn),
        .resetIn   (resetIn),
        .loadIn    (bufLoad),
        .loadData  (writeBackIn),
        .writeIn   (bufWrite),
        .writeIdx  (capIdx),
        .writeByte (ramDataIn),
        .readIdx   (cnt[BLOCK_WIDTH-1:0]),
        .readByte  (bufByte),
        .lineOut   (bufLine)
    );

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state    <= IDLE;
            cnt      <= '0;
            lineAddr <= '0;
            isFill   <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (bufLoad) begin
                lineAddr <= missAddrIn;
                isFill   <= readWriteIn;
            end
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        bufLoad      = 1'b0;
        bufWrite     = 1'b0;
        memDataValid = 1'b0;
        memAddr      = '0;
        memDataOut   = '0;
        acceptWrite  = 1'b0;
        busy         = (state != IDLE);
        ramAddrOut   = '0;
        ramDataOut   = '0;
        ramWriteOut  = RAM_READ;
        case (state)
            IDLE: begin
                if (startReq) begin
                    bufLoad   = 1'b1;
                    cntNext   = '0;
                    stateNext = readWriteIn ? READ : WRITE;
                end
            end
            READ: begin
                // RAM returns data one cycle late, so byte cnt-1 lands while address cnt goes out.
                if (cnt != CNT_FULL) begin
                    ramAddrOut = {lineAddr, cnt[BLOCK_WIDTH-1:0]};
                end
                bufWrite = (cnt != '0);
                if (clearIn) begin
                    stateNext = COOL;
                end else if (cnt == CNT_FULL) begin
                    stateNext = DONE;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            WRITE: begin
                ramAddrOut  = {lineAddr, cnt[BLOCK_WIDTH-1:0]};
                ramDataOut  = bufByte;
                ramWriteOut = RAM_WRITE;
                if (cnt == CNT_LAST) begin
                    stateNext = DONE;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DONE: begin
                memAddr   = lineAddr;
                stateNext = COOL;
                if (isFill) begin
                    if (!clearIn) begin
                        memDataValid = 1'b1;
                        memDataOut   = bufLine;
                    end
                end else begin
                    acceptWrite = 1'b1;
                end
            end
            COOL: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_line_mover.sv
// Directed self-checking bench for dcache_line_mover (BLOCK_WIDTH = 4).
module tb_dcache_line_mover;

    localparam int BW = 4;
    localparam int LW = 32 - BW;
    localparam int DW = 128;

    logic          clkIn = 1'b0;
    logic          resetIn;
    logic          clearIn;
    logic          missIn;
    logic [LW-1:0] missAddrIn;
    logic          readWriteIn;
    logic [DW-1:0] writeBackIn;
    logic          memDataValid;
    logic [LW-1:0] memAddr;
    logic [DW-1:0] memDataOut;
    logic          acceptWrite;
    logic          busy;
    logic [31:0]   ramAddrOut;
    logic [7:0]    ramDataOut;
    logic          ramWriteOut;
    logic [7:0]    ramDataIn = 8'h00;

    dcache_line_mover #(.BLOCK_WIDTH(BW)) dut (
        .clkIn        (clkIn),
        .resetIn      (resetIn),
        .clearIn      (clearIn),
        .missIn       (missIn),
        .missAddrIn   (missAddrIn),
        .readWriteIn  (readWriteIn),
        .writeBackIn  (writeBackIn),
        .memDataValid (memDataValid),
        .memAddr      (memAddr),
        .memDataOut   (memDataOut),
        .acceptWrite  (acceptWrite),
        .busy         (busy),
        .ramAddrOut   (ramAddrOut),
        .ramDataOut   (ramDataOut),
        .ramWriteOut  (ramWriteOut),
        .ramDataIn    (ramDataIn)
    );

    always #5 clkIn = ~clkIn;

    // RAM model: byte value equals the low address byte, returned one cycle after the address.
    always @(posedge clkIn) ramDataIn <= ramAddrOut[7:0];

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    logic [31:0]   addrLog [0:31];
    logic [31:0]   wrAddr  [0:31];
    logic [7:0]    wrData  [0:31];
    int            wrCyc   [0:31];
    int            wrN, nValid, nAccept, pulseCyc, busyEnd;
    logic [DW-1:0] gotData;
    logic [LW-1:0] gotAddr;

    // clrCyc: cycle (1 = first after accept) on which clearIn is raised; 0 = with the request, <0 = never.
    task automatic runXfer(input logic rw, input logic [LW-1:0] line, input logic [DW-1:0] data,
                           input int clrCyc);
        @(negedge clkIn);
        missIn = 1'b1; readWriteIn = rw; missAddrIn = line; writeBackIn = data;
        clearIn = (clrCyc == 0);
        wrN = 0; nValid = 0; nAccept = 0; pulseCyc = 0; busyEnd = 0;
        gotData = '0; gotAddr = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clkIn); #1;
            if (k == 1) begin
                missIn = 1'b0; readWriteIn = ~rw; missAddrIn = '1; writeBackIn = '1;
            end
            clearIn = (k == clrCyc);
            #1;
            addrLog[k] = ramAddrOut;
            if (ramWriteOut && wrN < 32) begin
                wrAddr[wrN] = ramAddrOut; wrData[wrN] = ramDataOut; wrCyc[wrN] = k; wrN++;
            end
            if (memDataValid) begin nValid++; pulseCyc = k; gotData = memDataOut; gotAddr = memAddr; end
            if (acceptWrite)  begin nAccept++; pulseCyc = k; gotAddr = memAddr; end
            if (!busy && busyEnd == 0) busyEnd = k;
        end
        clearIn = 1'b0;
    endtask

    typedef struct {
        logic          rw;
        logic [LW-1:0] line;
        logic [DW-1:0] data;
        int            expPulse;
        int            expBusyEnd;
        logic [DW-1:0] expData;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 28'h0000100, '0, 18, 20, 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[1] = '{1'b0, 28'h0000200, 128'h00112233445566778899AABBCCDDEEFF, 17, 19, '0};
        vecs[2] = '{1'b1, 28'h0FFFFFFF, '0, 18, 20, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0};
        vecs[3] = '{1'b0, 28'h0FFFFFFF, 128'h0123456789ABCDEF0011223344556677, 17, 19, '0};
        vecs[4] = '{1'b1, 28'h0000005, '0, 18, 20, 128'h5F5E5D5C5B5A59585756555453525150};

        resetIn = 1'b1; clearIn = 1'b0; missIn = 1'b0; readWriteIn = 1'b0;
        missAddrIn = '0; writeBackIn = '0;
        repeat (2) @(posedge clkIn);
        #1;
        check("reset_busy", busy, 0);
        check("reset_ramWrite", ramWriteOut, 0);
        check("reset_ramAddr", ramAddrOut, 0);
        check("reset_valid", memDataValid, 0);
        check("reset_accept", acceptWrite, 0);
        check("reset_memData", memDataOut, 0);
        @(negedge clkIn); resetIn = 1'b0;

        for (int i = 0; i < 5; i++) begin
            runXfer(vecs[i].rw, vecs[i].line, vecs[i].data, -1);
            check($sformatf("v%0d_pulse_cycle", i), pulseCyc, vecs[i].expPulse);
            check($sformatf("v%0d_addr", i), gotAddr, vecs[i].line);
            check($sformatf("v%0d_busy_end", i), busyEnd, vecs[i].expBusyEnd);
            if (vecs[i].rw) begin
                check($sformatf("v%0d_valid_count", i), nValid, 1);
                check($sformatf("v%0d_accept_count", i), nAccept, 0);
                check($sformatf("v%0d_fill_data", i), gotData, vecs[i].expData);
                check($sformatf("v%0d_ram_writes", i), wrN, 0);
                for (int j = 0; j < 16; j++) begin
                    logic [3:0] jb;
                    jb = 4'(j);
                    check($sformatf("v%0d_rd_addr%0d", i, j), addrLog[j+1], {vecs[i].line, jb});
                end
            end else begin
                check($sformatf("v%0d_accept_count", i), nAccept, 1);
                check($sformatf("v%0d_valid_count", i), nValid, 0);
                check($sformatf("v%0d_ram_writes", i), wrN, 16);
                for (int j = 0; j < 16; j++) begin
                    logic [3:0] jb;
                    jb = 4'(j);
                    check($sformatf("v%0d_wr_addr%0d", i, j), wrAddr[j], {vecs[i].line, jb});
                    check($sformatf("v%0d_wr_data%0d", i, j), wrData[j], vecs[i].data[8*j +: 8]);
                    check($sformatf("v%0d_wr_cyc%0d", i, j), wrCyc[j], j + 1);
                end
            end
        end

        // Flush during a fill: no fill reported, back to IDLE two cycles later.
        runXfer(1'b1, 28'h0000300, '0, 7);
        check("clr_fill_valid", nValid, 0);
        check("clr_fill_busy_end", busyEnd, 9);
        runXfer(1'b1, 28'h0000100, '0, -1);
        check("after_clr_valid", nValid, 1);
        check("after_clr_latency", pulseCyc, 18);
        check("after_clr_data", gotData, 128'h0F0E0D0C0B0A09080706050403020100);

        // Flush on the DONE cycle of a fill suppresses the pulse.
        runXfer(1'b1, 28'h0000100, '0, 18);
        check("clr_done_valid", nValid, 0);
        check("clr_done_busy_end", busyEnd, 20);

        // Flush during a writeback changes nothing.
        runXfer(1'b0, 28'h0000200, 128'h00112233445566778899AABBCCDDEEFF, 5);
        check("clr_wb_writes", wrN, 16);
        check("clr_wb_last_byte", wrData[15], 8'h00);
        check("clr_wb_accept", nAccept, 1);
        check("clr_wb_pulse", pulseCyc, 17);

        // Flush together with the request: fill refused, writeback started.
        runXfer(1'b1, 28'h0000100, '0, 0);
        check("clr_req_fill_busy", busyEnd, 1);
        check("clr_req_fill_reads", addrLog[2], 0);
        runXfer(1'b0, 28'h0000200, 128'h00112233445566778899AABBCCDDEEFF, 0);
        check("clr_req_wb_writes", wrN, 16);
        check("clr_req_wb_accept", nAccept, 1);

        // missIn held through DONE/COOL: next accept only from IDLE after COOL.
        begin
            int firstV, secondV, busy20, busy21, drained;
            @(negedge clkIn);
            missIn = 1'b1; readWriteIn = 1'b1; missAddrIn = 28'h0000400;
            nValid = 0; firstV = 0; secondV = 0; busy20 = -1; busy21 = -1;
            for (int k = 1; k <= 45; k++) begin
                @(posedge clkIn); #2;
                if (memDataValid) begin
                    nValid++;
                    if (nValid == 1) firstV = k; else secondV = k;
                end
                if (k == 20) busy20 = int'(busy);
                if (k == 21) busy21 = int'(busy);
            end
            missIn = 1'b0;
            check("held_valid_count", nValid, 2);
            check("held_first_pulse", firstV, 18);
            check("held_second_pulse", secondV, 38);
            check("held_idle_gap", busy20, 0);
            check("held_reaccept", busy21, 1);
            drained = 0;
            for (int k = 0; k < 40 && drained == 0; k++) begin
                @(posedge clkIn); #1;
                if (!busy) drained = 1;
            end
            check("held_drain", drained, 1);
        end

        // Asynchronous reset in the middle of a writeback.
        @(negedge clkIn);
        missIn = 1'b1; readWriteIn = 1'b0; missAddrIn = 28'h0000200;
        writeBackIn = 128'h00112233445566778899AABBCCDDEEFF;
        @(posedge clkIn); #1; missIn = 1'b0;
        repeat (4) @(posedge clkIn);
        #3;
        check("pre_rst_write", ramWriteOut, 1);
        resetIn = 1'b1;
        #1;
        check("rst_ramWrite", ramWriteOut, 0);
        check("rst_busy", busy, 0);
        check("rst_accept", acceptWrite, 0);
        check("rst_ramAddr", ramAddrOut, 0);
        @(negedge clkIn); @(negedge clkIn); resetIn = 1'b0;
        @(posedge clkIn); #1;
        check("post_rst_idle", busy, 0);
        runXfer(1'b1, 28'h0000100, '0, -1);
        check("post_rst_valid", nValid, 1);
        check("post_rst_latency", pulseCyc, 18);
        check("post_rst_data", gotData, 128'h0F0E0D0C0B0A09080706050403020100);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
